// File: rtl/key_pkg.sv
// Shared encodings for the keypad press classifier: per-channel hold levels,
// FSM state codes and the default scanner code map.
package key_pkg;

  localparam logic [1:0] KEY_RELEASED = 2'd0;
  localparam logic [1:0] KEY_SHORT    = 2'd1;
  localparam logic [1:0] KEY_LONG     = 2'd2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_SHORT    = 2'd2;
  localparam logic [1:0] ST_LONG     = 2'd3;

  // Channel 0 sits in the low nibble: ch0=D, ch1=5, ch2=8, ch3=A, ch4=0, ch5=9.
  localparam logic [23:0] DEFAULT_KEY_CODES = {4'h9, 4'h0, 4'hA, 4'h8, 4'h5, 4'hD};

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk tick every TICK_DIV clocks;
// shared with the display scan logic.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/key_press_classifier.sv
// Debounces the scanner's active key code against a channel map and reports
// per-channel hold level plus press/click/long/repeat/release pulses.
//
//  state    | meaning
//  IDLE     | no mapped key held
//  DEBOUNCE | mapped key seen, waiting for DEBOUNCE_TICKS stable samples
//  SHORT    | press accepted, counting toward long-press
//  LONG     | long-held, emitting repeat pulses every REPEAT_TICKS
module key_press_classifier
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 6,
  parameter int CODE_W         = 4,
  parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES = DEFAULT_KEY_CODES,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [CODE_W-1:0]       key_code,
  output logic [2*NUM_KEYS-1:0]   key_state,
  output logic [NUM_KEYS-1:0]     press_pulse,
  output logic [NUM_KEYS-1:0]     click_pulse,
  output logic [NUM_KEYS-1:0]     long_pulse,
  output logic [NUM_KEYS-1:0]     repeat_pulse,
  output logic [NUM_KEYS-1:0]     release_pulse
);

  localparam int CH_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;

  if (LONG_TICKS <= DEBOUNCE_TICKS || (LONG_TICKS >> CNT_W) != 0) begin : g_bad_long
    $error("key_press_classifier: LONG_TICKS must exceed DEBOUNCE_TICKS and fit in CNT_W bits");
  end
  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1) begin : g_bad_timing
    $error("key_press_classifier: TICK_DIV must be >= 2 and DEBOUNCE_TICKS >= 1");
  end

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [1:0]       st, st_n;
  logic [CH_W-1:0]  cur_ch, ch_n, hit_ch;
  logic [CNT_W-1:0] hold_cnt, hold_n, hold_inc;
  logic [REP_W-1:0] rep_cnt, rep_n, rep_inc;
  logic             hit;
  logic [NUM_KEYS-1:0] press_n, click_n, long_n, repeat_n, release_n;
  logic [2*NUM_KEYS-1:0] state_n;

  function automatic logic [NUM_KEYS-1:0] ch_bit(input logic [CH_W-1:0] ch);
    ch_bit = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (ch == CH_W'(i)) ch_bit[i] = 1'b1;
  endfunction

  // Scan from the top so the lowest matching channel wins on duplicate codes.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_valid && key_code == KEY_CODES[i*CODE_W +: CODE_W]) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  assign hold_inc = hold_cnt + 1'b1;
  assign rep_inc  = rep_cnt + 1'b1;

  always_comb begin
    st_n      = st;
    ch_n      = cur_ch;
    hold_n    = hold_cnt;
    rep_n     = rep_cnt;
    press_n   = '0;
    click_n   = '0;
    long_n    = '0;
    repeat_n  = '0;
    release_n = '0;
    if (tick) begin
      case (st)
        ST_IDLE: begin
          if (hit) begin
            ch_n   = hit_ch;
            hold_n = CNT_W'(1);
            if (DEBOUNCE_TICKS <= 1) begin
              st_n    = ST_SHORT;
              press_n = ch_bit(hit_ch);
            end else begin
              st_n = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!hit) begin
            st_n   = ST_IDLE;
            hold_n = '0;
          end else if (hit_ch == cur_ch) begin
            hold_n = hold_inc;
            if (hold_inc >= CNT_W'(DEBOUNCE_TICKS)) begin
              st_n    = ST_SHORT;
              press_n = ch_bit(cur_ch);
            end
          end else begin
            ch_n   = hit_ch;
            hold_n = CNT_W'(1);
          end
        end
        ST_SHORT, ST_LONG: begin
          if (!hit) begin
            st_n      = ST_IDLE;
            hold_n    = '0;
            rep_n     = '0;
            release_n = ch_bit(cur_ch);
            if (st == ST_SHORT) click_n = ch_bit(cur_ch);
          end else if (hit_ch != cur_ch) begin
            // Old channel releases now; the new one must re-debounce before its press.
            st_n      = ST_DEBOUNCE;
            ch_n      = hit_ch;
            hold_n    = CNT_W'(1);
            rep_n     = '0;
            release_n = ch_bit(cur_ch);
          end else if (st == ST_SHORT) begin
            hold_n = hold_inc;
            if (hold_inc >= CNT_W'(LONG_TICKS)) begin
              st_n   = ST_LONG;
              long_n = ch_bit(cur_ch);
              rep_n  = '0;
            end
          end else begin
            if (hold_cnt != '1) hold_n = hold_inc;
            if (REPEAT_TICKS > 0) begin
              if (rep_inc >= REP_W'(REPEAT_TICKS)) begin
                rep_n    = '0;
                repeat_n = ch_bit(cur_ch);
              end else begin
                rep_n = rep_inc;
              end
            end
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    state_n = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_n[2*i +: 2] = KEY_RELEASED;
      if (ch_n == CH_W'(i)) begin
        if (st_n == ST_SHORT)     state_n[2*i +: 2] = KEY_SHORT;
        else if (st_n == ST_LONG) state_n[2*i +: 2] = KEY_LONG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_IDLE;
      cur_ch        <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      key_state     <= '0;
      press_pulse   <= '0;
      click_pulse   <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      release_pulse <= '0;
    end else begin
      st            <= st_n;
      cur_ch        <= ch_n;
      hold_cnt      <= hold_n;
      rep_cnt       <= rep_n;
      key_state     <= state_n;
      press_pulse   <= press_n;
      click_pulse   <= click_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      release_pulse <= release_n;
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench: each step drives one input for exactly one tick period
// (TICK_DIV=2) and checks hold state, pulses and pulse widths.
module tb_key_press_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] key_state;
  logic [5:0]  press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_press_classifier #(
    .NUM_KEYS       (6),
    .CODE_W         (4),
    .KEY_CODES      (24'h90A85D),
    .TICK_DIV       (2),
    .DEBOUNCE_TICKS (3),
    .LONG_TICKS     (8),
    .REPEAT_TICKS   (2),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse word layout: {release, repeat, long, click, press}, 6 bits each.
  task automatic step(input string tag, input logic v, input logic [3:0] c,
                      input logic [11:0] e_st, input logic [5:0] e_pr, input logic [5:0] e_cl,
                      input logic [5:0] e_lg, input logic [5:0] e_rp, input logic [5:0] e_rl);
    logic [29:0] acc, exp_p;
    int bits;
    key_valid = v;
    key_code  = c;
    acc  = '0;
    bits = 0;
    exp_p = {e_rl, e_rp, e_lg, e_cl, e_pr};
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      acc  |= {release_pulse, repeat_pulse, long_pulse, click_pulse, press_pulse};
      bits += $countones({release_pulse, repeat_pulse, long_pulse, click_pulse, press_pulse});
    end
    check($sformatf("%s.state", tag), 32'(key_state), 32'(e_st));
    check($sformatf("%s.pulses", tag), 32'(acc), 32'(exp_p));
    check($sformatf("%s.width", tag), 32'(bits), 32'($countones(exp_p)));
  endtask

  task automatic all_zero(input string tag);
    check($sformatf("%s.state", tag), 32'(key_state), 32'd0);
    check($sformatf("%s.pulses", tag),
          32'({release_pulse, repeat_pulse, long_pulse, click_pulse, press_pulse}), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    reset = 1'b0;

    // Short click on ch1 (code 5)
    step("clk1", 1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("clk2", 1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("clk3", 1, 4'h5, 12'h004, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00);
    step("clk4", 1, 4'h5, 12'h004, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("clk5", 1, 4'h5, 12'h004, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("clk6", 0, 4'h5, 12'h000, 6'h00, 6'h02, 6'h00, 6'h00, 6'h02);
    step("clk7", 0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);

    // Bounce on ch0 (code D): never reaches three stable samples
    step("bnc1", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("bnc2", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("bnc3", 0, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("bnc4", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("bnc5", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("bnc6", 0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);

    // Long hold with repeat on ch3 (code A)
    step("lng1", 1, 4'hA, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("lng2", 1, 4'hA, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("lng3", 1, 4'hA, 12'h040, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00);
    for (int t = 4; t <= 7; t++)
      step($sformatf("lng%0d", t), 1, 4'hA, 12'h040, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("lng8", 1, 4'hA, 12'h080, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00);
    for (int t = 9; t <= 14; t++)
      step($sformatf("lng%0d", t), 1, 4'hA, 12'h080, 6'h00, 6'h00, 6'h00,
           (t % 2 == 0) ? 6'h08 : 6'h00, 6'h00);
    step("lng15", 0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08);

    // Channel switch ch2 (8) -> ch4 (0) without a gap
    step("sw1", 1, 4'h8, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw2", 1, 4'h8, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw3", 1, 4'h8, 12'h010, 6'h04, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw4", 1, 4'h8, 12'h010, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw5", 1, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04);
    step("sw6", 1, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw7", 1, 4'h0, 12'h100, 6'h10, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw8", 1, 4'h0, 12'h100, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("sw9", 0, 4'h0, 12'h000, 6'h00, 6'h10, 6'h00, 6'h00, 6'h10);

    // Debounce restarts when a different mapped key appears
    step("rst1", 1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rst2", 1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rst3", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rst4", 1, 4'hD, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rst5", 1, 4'hD, 12'h001, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rst6", 0, 4'hD, 12'h000, 6'h00, 6'h01, 6'h00, 6'h00, 6'h01);

    // Unmapped code, and a mapped code with key_valid low
    for (int t = 1; t <= 4; t++)
      step($sformatf("unm%0d", t), 1, 4'hF, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    for (int t = 1; t <= 3; t++)
      step($sformatf("inv%0d", t), 0, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);

    // Reset during a long hold on ch5 (code 9)
    step("rh1", 1, 4'h9, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh2", 1, 4'h9, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh3", 1, 4'h9, 12'h400, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00);
    for (int t = 4; t <= 7; t++)
      step($sformatf("rh%0d", t), 1, 4'h9, 12'h400, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh8", 1, 4'h9, 12'h800, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00);
    step("rh9", 1, 4'h9, 12'h800, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    all_zero("rh_rst1");
    @(posedge clk);
    @(negedge clk);
    all_zero("rh_rst2");
    reset = 1'b0;
    step("rh_post", 0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh_r1", 1, 4'h9, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh_r2", 1, 4'h9, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh_r3", 1, 4'h9, 12'h400, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00);
    step("rh_r4", 0, 4'h0, 12'h000, 6'h00, 6'h20, 6'h00, 6'h00, 6'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
